window_sender: RTL and testbench

Transmit side of the timed-window interface. Accepts a request (window length plus a 16-bit payload) over a valid/ready handshake. Drives a one-cycle `timer` load followed by one payload bit per cycle on `data` for exactly `len` cycles, then a one-cycle drain. This matches the countdown behaviour of the window receiver, which loads `timer` in its idle state, counts down once per cycle, and returns to idle one cycle after reaching zero.

---
 rtl/window_pkg.sv | 15 +
 rtl/window_counter.sv | 31 +++
 rtl/window_sender.sv | 105 ++++++++++
 tb/tb_window_sender.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/window_pkg.sv
// Shared definitions for the timed-window interface (sender and receiver sides).
// Holds the window FSM state encoding, default width and the default mark word.
package window_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SEND  = 2'd2,
    DRAIN = 2'd3
  } win_state_t;

  localparam int              WIN_WIDTH = 16;
  localparam logic [15:0]     WIN_MARK  = 16'hFFFF;

endpackage

// File: rtl/window_counter.sv
// Loadable down-counter holding the cycles remaining in a window.
// Saturates at zero and exposes a zero flag.
module window_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_r;

  assign zero = (count_r == {WIDTH{1'b0}});

  // Count register: load wins over decrement; never wraps below zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (dec && !zero) begin
      count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/window_sender.sv
// Transmit side of the timed-window interface: one timer load cycle, len payload
// cycles (LSB first, rotating every 16 bits), then a one-cycle drain with done.
module window_sender
  import window_pkg::*;
#(
  parameter int               WIDTH = WIN_WIDTH,
  parameter logic [WIDTH-1:0] MARK  = WIN_MARK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_len,
  input  logic [WIDTH-1:0] req_data,
  output logic             req_ready,
  output logic [WIDTH-1:0] timer,
  output logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done
);

  win_state_t       state_r;
  win_state_t       state_s;
  logic [WIDTH-1:0] payload_r;
  logic [3:0]       idx_r;
  logic             accept_s;
  logic             len_nz_s;
  logic             cnt_load_s;
  logic             cnt_dec_s;
  logic             cnt_zero_s;

  assign req_ready = ((state_r == IDLE) || (state_r == DRAIN)) && !reset;
  assign accept_s  = req_valid && req_ready;
  assign len_nz_s  = (req_len != {WIDTH{1'b0}});

  window_counter #(.WIDTH(WIDTH)) u_remaining (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load_s),
    .load_value (req_len),
    .dec        (cnt_dec_s),
    .zero       (cnt_zero_s)
  );

  // Next-state and counter control; a zero-length request skips straight to DRAIN.
  always_comb begin
    state_s    = state_r;
    cnt_load_s = 1'b0;
    case (state_r)
      IDLE, DRAIN: begin
        if (accept_s) begin
          state_s    = len_nz_s ? LOAD : DRAIN;
          cnt_load_s = len_nz_s;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        state_s = SEND;
      end
      SEND: begin
        if (cnt_zero_s) begin
          state_s = DRAIN;
        end else begin
          state_s = SEND;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    cnt_dec_s = (state_s == SEND);
  end

  // State, payload/index and registered outputs, all derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      payload_r <= {WIDTH{1'b0}};
      idx_r     <= 4'd0;
      timer     <= {WIDTH{1'b0}};
      data      <= {WIDTH{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r <= state_s;
      if (cnt_load_s) begin
        payload_r <= req_data;
        idx_r     <= 4'd0;
      end else if (state_s == SEND) begin
        idx_r <= idx_r + 4'd1;
      end else begin
        idx_r <= idx_r;
      end
      timer <= (state_s == LOAD) ? req_len : {WIDTH{1'b0}};
      if (state_s == SEND) begin
        data <= payload_r[idx_r] ? MARK : {WIDTH{1'b0}};
      end else begin
        data <= {WIDTH{1'b0}};
      end
      busy <= (state_s == LOAD) || (state_s == SEND);
      done <= (state_s == DRAIN);
    end
  end

endmodule

// File: tb/tb_window_sender.sv
// Scoreboard bench for window_sender: expected per-cycle output records are queued
// at acceptance from a cycle-timestamped window model and matched by a monitor.
module tb_window_sender;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [15:0] req_len;
  logic [15:0] req_data;
  logic        req_ready;
  logic [15:0] timer;
  logic [15:0] data;
  logic        busy;
  logic        done;

  typedef struct {
    int          cyc;
    logic [15:0] timer;
    logic [15:0] data;
    logic        busy;
    logic        done;
  } rec_t;

  rec_t exp_q[$];
  rec_t mon_r;
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   free_cyc   = 0;
  bit   mon_en     = 1'b0;

  window_sender #(.WIDTH(16), .MARK(16'hFFFF)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_len   (req_len),
    .req_data  (req_data),
    .req_ready (req_ready),
    .timer     (timer),
    .data      (data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int got, int want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, want);
    end
  endtask

  // Window seen from outside: accepted on the edge ending cycle c.
  task automatic push_window(int c, int n, logic [15:0] pl);
    rec_t r;
    if (n == 0) begin
      r = '{c + 1, 16'h0, 16'h0, 1'b0, 1'b1};
      exp_q.push_back(r);
      free_cyc = c + 1;
    end else begin
      r = '{c + 1, n[15:0], 16'h0, 1'b1, 1'b0};
      exp_q.push_back(r);
      for (int j = 0; j < n; j++) begin
        r = '{c + 2 + j, 16'h0, pl[j % 16] ? 16'hFFFF : 16'h0000, 1'b1, 1'b0};
        exp_q.push_back(r);
      end
      r = '{c + n + 2, 16'h0, 16'h0, 1'b0, 1'b1};
      exp_q.push_back(r);
      free_cyc = c + n + 2;
    end
  endtask

  task automatic send(int n, logic [15:0] pl);
    bit ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_len   = n[15:0];
      req_data  = pl;
      #1;
      check("req_ready", int'(req_ready), int'(cyc >= free_cyc));
      if (cyc >= free_cyc) begin
        push_window(cyc, n, pl);
        ok = 1'b1;
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: request len=%0d not accepted, expected acceptance within 200 cycles", n);
    end
  endtask

  task automatic idle(int k);
    repeat (k) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_len   = 16'($urandom);
      req_data  = 16'($urandom);
      #1;
      check("req_ready_idle", int'(req_ready), int'(cyc >= free_cyc));
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    req_valid = 1'($urandom % 2);
    reset     = 1'b1;
    #1;
    check("ready_in_reset", int'(req_ready), 0);
    while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    reset     = 1'b0;
    req_valid = 1'b0;
    free_cyc  = cyc;
  endtask

  // Monitor: every cycle either matches the queued record for that cycle or is quiet.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        mon_r = exp_q.pop_front();
        compared++;
        if (timer !== mon_r.timer || data !== mon_r.data ||
            busy !== mon_r.busy || done !== mon_r.done) begin
          mismatched++;
          $display("FAIL window_cycle cyc=%0d got timer=%h data=%h busy=%b done=%b, expected timer=%h data=%h busy=%b done=%b",
                   cyc, timer, data, busy, done, mon_r.timer, mon_r.data, mon_r.busy, mon_r.done);
        end
      end else begin
        compared++;
        if (timer !== 16'h0 || data !== 16'h0 || busy !== 1'b0 || done !== 1'b0) begin
          mismatched++;
          $display("FAIL idle_output cyc=%0d got timer=%h data=%h busy=%b done=%b, expected all zero",
                   cyc, timer, data, busy, done);
        end
      end
    end
  end

  initial begin
    int n;
    int sel;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_len   = 16'h0;
    req_data  = 16'h0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ready", int'(req_ready), 0);
    check("reset_timer", int'(timer), 0);
    check("reset_data", int'(data), 0);
    check("reset_busy0", int'(busy), 0);
    check("reset_done0", int'(done), 0);
    @(negedge clk);
    reset    = 1'b0;
    free_cyc = cyc;
    mon_en   = 1'b1;

    send(3, 16'b101);
    idle(6);
    send(0, 16'($urandom));
    send(7, 16'($urandom));
    idle(12);
    send(2, 16'($urandom));
    send(1, 16'($urandom));
    idle(5);
    send(18, 16'h0003);
    idle(22);
    send(5, 16'hFFFF);
    idle(3);
    reset_pulse();
    idle(3);

    for (int i = 0; i < 200; i++) begin
      sel = int'($urandom % 20);
      if (sel == 0) begin
        reset_pulse();
      end else if (sel < 6) begin
        idle(int'($urandom_range(1, 3)));
      end else begin
        sel = int'($urandom % 8);
        if (sel == 0)      n = 0;
        else if (sel == 1) n = int'($urandom_range(16, 34));
        else               n = int'($urandom_range(1, 6));
        send(n, 16'($urandom));
      end
    end

    idle(40);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
